oam_dma_ctrl: RTL
=================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
REQ-002 Parameter OAM_DATA_ADDR, 16'h2004, PPU OAM data port written during a transfer.
REQ-003 cpuClk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpuAddr  input  16  CPU bus address request.
REQ-006 cpuDataWr  input  8  CPU write data.
REQ-007 cpuWrEn  input  1  CPU write strobe (1 = write).
REQ-008 dataRd  input  8  memory read data, valid combinationally in the same cycle as busAddr.
REQ-009 busAddr  output  16  arbitrated address to memory map.
REQ-010 busDataWr  output  8  arbitrated write data.
REQ-011 busWrEn  output  1  arbitrated write strobe.
REQ-012 cpuHalt  output  1  1 = CPU must hold all state this cycle (RDY low).
REQ-013 dmaActive  output  1  1 while the controller owns the bus.

Function
REQ-014 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 IDLE: bus outputs SHALL equal cpuAddr/cpuDataWr/cpuWrEn; cpuHalt=0; dmaActive=0.
REQ-016 IDLE with cpuWrEn=1 and cpuAddr==DMA_REG_ADDR: write passes through to bus that cycle; page register latches cpuDataWr; byte counter cleared to 0; next state HALT.
REQ-017 In every non-IDLE state cpuHalt=1, dmaActive=1, and CPU bus requests SHALL be ignored (never reach the bus).
REQ-018 HALT: dummy cycle, busAddr=cpuAddr, busWrEn=0; next state per REQ-033/034.
REQ-019 ALIGN: busAddr=cpuAddr, busWrEn=0; next state READ.
REQ-020 READ: busAddr={page, count}, busWrEn=0; dataRd captured into byte latch at cycle end; next state WRITE.
REQ-021 WRITE: busAddr=OAM_DATA_ADDR, busDataWr=byte latch, busWrEn=1; count increments by 1.
REQ-022 WRITE with count==8'hFF: next state IDLE; cpuHalt deasserts the following cycle; otherwise next state READ.
REQ-023 Count SHALL be 8 bits; source address never carries into the page byte (page 8'hFF ends at 16'hFFFF).
REQ-024 Transfer SHALL move exactly 256 bytes in ascending source order.
REQ-025 Free-running 1-bit cycleParity SHALL toggle every cycle from reset, regardless of state.
REQ-026 Writes to DMA_REG_ADDR while not IDLE SHALL have no effect (page, count, state unchanged).
REQ-027 busDataWr SHALL be 8'h00 whenever busWrEn=0 outside IDLE.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, page 8'h00, count 8'h00, byte latch 8'h00, cycleParity 0.
REQ-029 During reset: cpuHalt=0, dmaActive=0, bus outputs mirror CPU inputs.
REQ-030 Reset asserted mid-transfer SHALL abort it; no further OAM writes after release; no resume.

Configuration
REQ-031 Macro OAM_DMA_ODD_ALIGN_EN SHALL select get/put cycle alignment.
REQ-032 With OAM_DMA_ODD_ALIGN_EN defined, every READ SHALL occur with cycleParity==0.
REQ-033 Defined: HALT goes to ALIGN if cycleParity==0, else READ; total halt = 513 or 514 cycles.
REQ-034 Undefined: ALIGN unreachable; HALT always goes to READ; total halt = 513 cycles.

Verification
REQ-035 Fill RAM 0x0200-0x02FF with i; CPU writes 8'h02 to 4014 -> 256 writes to 2004 with data 0x00..0xFF in order, busWrEn pattern 0,1 alternating.
REQ-036 Trigger with cycleParity 1 at HALT (macro on) -> cpuHalt high exactly 513 cycles; repeat with parity 0 -> exactly 514; macro off -> 513 both cases.
REQ-037 Page 8'hFF trigger -> last read address 16'hFFFF, then IDLE; no access to 16'h0000.
REQ-038 During transfer CPU drives write 8'h55 to 4014 and to 0x0300 -> neither reaches bus; page stays 8'h02.
REQ-039 Assert reset after 100th OAM write -> cpuHalt=0 immediately; after release no 2004 writes; new trigger restarts at count 0.
REQ-040 CPU write to 4013 or read of 4014 -> pass-through only, cpuHalt stays 0.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - OAM DMA sequencer and CPU/DMA bus arbiter
// Build option: OAM_DMA_ODD_ALIGN_EN inserts an ALIGN cycle so every READ lands on cycleParity==0.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        cpuClk,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataWr,
  input  logic        cpuWrEn,
  input  logic [7:0]  dataRd,
  output logic [15:0] busAddr,
  output logic [7:0]  busDataWr,
  output logic        busWrEn,
  output logic        cpuHalt,
  output logic        dmaActive
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  state_t      state;
  state_t      state_next;
  logic [7:0]  page;
  logic [7:0]  count;
  logic [7:0]  byte_latch;
  logic        cycle_parity;
  logic        trigger;

  assign trigger = (state == IDLE) && cpuWrEn && (cpuAddr == DMA_REG_ADDR);

  always_ff @(posedge cpuClk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      page         <= 8'h00;
      count        <= 8'h00;
      byte_latch   <= 8'h00;
      cycle_parity <= 1'b0;
    end else begin
      state        <= state_next;
      cycle_parity <= ~cycle_parity;
      if (trigger) begin
        page  <= cpuDataWr;
        count <= 8'h00;
      end
      if (state == READ) begin
        byte_latch <= dataRd;
      end
      // 8-bit wrap keeps the source inside the selected page
      if (state == WRITE) begin
        count <= count + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    busAddr    = cpuAddr;
    busDataWr  = cpuDataWr;
    busWrEn    = cpuWrEn;
    cpuHalt    = 1'b0;
    dmaActive  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = HALT;
        end
      end
      HALT: begin
        cpuHalt    = 1'b1;
        dmaActive  = 1'b1;
        busDataWr  = 8'h00;
        busWrEn    = 1'b0;
        // Odd-aligned build: a READ must fall on parity 0, so burn one cycle if HALT is on 0
        state_next = (ALIGN_EN && !cycle_parity) ? ALIGN : READ;
      end
      ALIGN: begin
        cpuHalt    = 1'b1;
        dmaActive  = 1'b1;
        busDataWr  = 8'h00;
        busWrEn    = 1'b0;
        state_next = READ;
      end
      READ: begin
        cpuHalt    = 1'b1;
        dmaActive  = 1'b1;
        busAddr    = {page, count};
        busDataWr  = 8'h00;
        busWrEn    = 1'b0;
        state_next = WRITE;
      end
      WRITE: begin
        cpuHalt    = 1'b1;
        dmaActive  = 1'b1;
        busAddr    = OAM_DATA_ADDR;
        busDataWr  = byte_latch;
        busWrEn    = 1'b1;
        state_next = (count == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
